// File: rtl/dco_ctrl_pkg.sv
// Shared definitions for the DCO control blocks: default widths, sweep state
// encoding and the saturating increment arithmetic.
package dco_ctrl_pkg;

  localparam int DCO_PHASE_INCREMENT_BITS = 28;
  localparam int DCO_DWELL_BITS           = 16;
  localparam int DCO_COUNT_BITS           = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DWELL,
    STEP,
    FINISH
  } sweep_state_t;

  // Operands are carried in 64 bits; the ceiling is 2^width-1 of the real field.
  function automatic logic [63:0] sat_add_sub(input logic [63:0] cur,
                                              input logic [63:0] step,
                                              input logic        down,
                                              input int          width);
    logic [64:0] sum;
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sum     = {1'b0, cur} + {1'b0, step};
    if (down)
      return (step > cur) ? 64'd0 : (cur - step);
    return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
  endfunction

endpackage

// File: rtl/dco_sweep_ctrl.sv
// Linear frequency sweep sequencer: sole writer of the DCO phase-increment
// port, stepping a start value up or down with a fixed dwell per value.
module dco_sweep_ctrl
  import dco_ctrl_pkg::*;
#(
  parameter int PHASE_INCREMENT_BITS = DCO_PHASE_INCREMENT_BITS,
  parameter int DWELL_BITS           = DCO_DWELL_BITS,
  parameter int COUNT_BITS           = DCO_COUNT_BITS
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            CE,
  input  logic                            START_IN,
  input  logic                            ABORT_IN,
  input  logic [PHASE_INCREMENT_BITS-1:0] CFG_START,
  input  logic [PHASE_INCREMENT_BITS-1:0] CFG_STEP,
  input  logic                            CFG_DOWN,
  input  logic [COUNT_BITS-1:0]           CFG_COUNT,
  input  logic [DWELL_BITS-1:0]           CFG_DWELL,
  output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
  output logic                            PHASE_INCREMENT_WE,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ABORTED,
  output logic [COUNT_BITS-1:0]           STEP_INDEX
);

  sweep_state_t                    state;
  logic [PHASE_INCREMENT_BITS-1:0] inc_q;
  logic [PHASE_INCREMENT_BITS-1:0] step_q;
  logic                            down_q;
  logic [DWELL_BITS-1:0]           reload_q;
  logic [DWELL_BITS-1:0]           dwell_cnt;
  logic [COUNT_BITS-1:0]           remaining;
  logic [COUNT_BITS-1:0]           step_index_q;
  logic                            we_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            aborted_q;

  logic [DWELL_BITS-1:0]           cfg_reload;
  logic [PHASE_INCREMENT_BITS-1:0] next_inc;
  logic                            abort_now;

  // A zero dwell behaves like a dwell of one cycle.
  assign cfg_reload = (CFG_DWELL == '0) ? '0 : (CFG_DWELL - DWELL_BITS'(1));
  assign next_inc   = PHASE_INCREMENT_BITS'(sat_add_sub(64'(inc_q), 64'(step_q), down_q,
                                                        PHASE_INCREMENT_BITS));
  assign abort_now  = ABORT_IN && ((state == LOAD) || (state == DWELL) || (state == STEP));

  // Outputs are registered for the state being entered; an aborted sweep
  // spends two cycles in FINISH: the zero-write, then the DONE pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      inc_q        <= '0;
      step_q       <= '0;
      down_q       <= 1'b0;
      reload_q     <= '0;
      dwell_cnt    <= '0;
      remaining    <= '0;
      step_index_q <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (CE) begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort_now) begin
        inc_q     <= '0;
        we_q      <= 1'b1;
        aborted_q <= 1'b1;
        state     <= FINISH;
      end else begin
        unique case (state)
          IDLE: begin
            if (START_IN) begin
              step_q       <= CFG_STEP;
              down_q       <= CFG_DOWN;
              reload_q     <= cfg_reload;
              dwell_cnt    <= cfg_reload;
              remaining    <= CFG_COUNT;
              inc_q        <= CFG_START;
              step_index_q <= '0;
              we_q         <= 1'b1;
              busy_q       <= 1'b1;
              aborted_q    <= 1'b0;
              state        <= LOAD;
            end
          end
          LOAD, STEP: state <= DWELL;
          DWELL: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_BITS'(1);
            end else if (remaining != '0) begin
              inc_q        <= next_inc;
              we_q         <= 1'b1;
              step_index_q <= step_index_q + COUNT_BITS'(1);
              remaining    <= remaining - COUNT_BITS'(1);
              dwell_cnt    <= reload_q;
              state        <= STEP;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end
          end
          FINISH: begin
            if (done_q) begin
              state <= IDLE;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign PHASE_INCREMENT_OUT = inc_q;
  assign PHASE_INCREMENT_WE  = we_q & CE;
  assign BUSY                = busy_q;
  assign DONE                = done_q;
  assign ABORTED             = aborted_q;
  assign STEP_INDEX          = step_index_q;

endmodule

// File: doc/dco_sweep_ctrl.md
# dco_sweep_ctrl

Sequencer that drives the phase-increment write port of the sin/cos DCO through a programmed linear frequency sweep: it loads a start increment, holds each increment for a fixed dwell, then steps it up or down a set number of times. It sits between the host or register block and the DCO, and is the only writer of the DCO phase increment. The DCO captures a new increment on the cycle where CE=1 and WE=1.

## Interface
- PHASE_INCREMENT_BITS, 28: width of the phase increment (matches DCO).
- DWELL_BITS, 16: width of the dwell-length counter.
- COUNT_BITS, 12: width of the step-count field.

- CLK  in  1  clock.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- CE  in  1  clock enable; all state advances only when CE=1.
- START_IN  in  1  begin sweep; sampled only in IDLE with CE=1.
- ABORT_IN  in  1  cancel a running sweep.
- CFG_START  in  PHASE_INCREMENT_BITS  first increment.
- CFG_STEP  in  PHASE_INCREMENT_BITS  unsigned step magnitude.
- CFG_DOWN  in  1  0 = add step, 1 = subtract step.
- CFG_COUNT  in  COUNT_BITS  number of steps after the first load (0 = load only).
- CFG_DWELL  in  DWELL_BITS  cycles (CE cycles) per increment; 0 treated as 1.
- PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  increment to the DCO.
- PHASE_INCREMENT_WE  out  1  write strobe to the DCO.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse at sweep end.
- ABORTED  out  1  qualifies DONE; held until the next START.
- STEP_INDEX  out  COUNT_BITS  index of the increment currently applied.

## Operation
- States:
  - IDLE: waits for START_IN.
  - LOAD: writes CFG_START.
  - DWELL: counts down.
  - STEP: writes the next value.
  - FINISH: emits DONE.
- IDLE: when START_IN=1, capture all CFG_* into internal registers and go to LOAD. CFG_* changes after capture have no effect.
- LOAD: OUT=CFG_START, WE=1, STEP_INDEX=0, dwell counter = max(CFG_DWELL,1)-1, remaining = CFG_COUNT. Then go to DWELL.
- DWELL: decrement the counter. At 0: go to STEP if remaining>0, else FINISH.
- STEP: OUT = sat(cur ± step), WE=1, STEP_INDEX+1, remaining-1, reload the counter. Then go to DWELL.
- Saturation:
  - Up: clamp at 2^PHASE_INCREMENT_BITS-1.
  - Down: clamp at 0.
  - Once clamped, remaining steps still execute and rewrite the clamped value.
- FINISH: DONE=1 for one cycle, BUSY=0, then IDLE.
- ABORT_IN=1 in LOAD/DWELL/STEP: write OUT=0 with WE=1 (silences the DCO), set ABORTED=1, go to FINISH.
  - ABORT wins over a coincident STEP or LOAD write.
  - ABORT_IN in IDLE or FINISH is ignored.
- START_IN while BUSY is ignored. START_IN and ABORT_IN together in IDLE: the sweep starts and the abort is ignored.
- WE is asserted only in cycles with CE=1. With CE=0 all registers and outputs hold, except WE, which is forced to 0.

## Timing
- Reset values: PHASE_INCREMENT_OUT=0, WE=0, BUSY=0, DONE=0, ABORTED=0, STEP_INDEX=0, state IDLE.
- Cycle counts below are CE=1 cycles. Let D = max(CFG_DWELL,1), N = CFG_COUNT, START sampled at cycle t.
- t+1: LOAD, WE=1, BUSY=1.
- Step k (1..N) is written at t+1+k·(D+1), since each STEP cycle is followed by D DWELL cycles.
- DONE is asserted at t+1+(N+1)·(D+1)-… see note. Exactly: the last DWELL ends at t+1+N·(D+1)+D, and DONE is asserted the next cycle, t+2+N·(D+1)+D.
- Each increment is applied (WE to next WE) for exactly D+1 cycles.
- Abort: zero-write in the cycle after ABORT_IN, DONE the cycle after that.
- BUSY is high from LOAD through the last DWELL cycle and low in FINISH.
- Next START is accepted one cycle after DONE.
- RESET mid-sweep: all outputs return to reset values next cycle. No zero-write is issued; the DCO is reset by the same RESET.

## Structure
- Shared package dco_ctrl_pkg:
  - state encoding (IDLE, LOAD, DWELL, STEP, FINISH);
  - saturating add/sub function parameterised on width;
  - default widths shared with sin_cos_dco.
- Single module with no sub-modules. The dwell counter and step arithmetic stay inline.

## Test plan
- CFG_START=1000, STEP=100, up, COUNT=3, DWELL=4 → WE pulses writing 1000, 1100, 1200, 1300, spaced 5 cycles apart; DONE 5 cycles after the last write; ABORTED=0.
- CFG_START=150, STEP=100, down, COUNT=3 → writes 150, 50, 0, 0 (clamp); STEP_INDEX reaches 3.
- CFG_START=2^28-50, STEP=100, up, COUNT=2 → writes 2^28-50, 2^28-1, 2^28-1.
- ABORT_IN during the 2nd dwell → next cycle writes 0 with WE=1, then DONE with ABORTED=1; a START issued during the sweep was ignored.
- CE toggling 1/0 every cycle with DWELL=0, COUNT=2 → same write sequence as CE=1 stretched over CE=1 cycles; WE never high while CE=0.
- RESET asserted mid-DWELL → all outputs at reset values next cycle; a new START then sweeps normally.
